potential_decay_engine: RTL and testbench

- Parametrised, sequential successor of the single-neuron LIF decay block.
- Holds membrane potentials (IEEE-754 single) and per-neuron decay shifts for NEURONS neurons in an internal register array.
- On each timestep `clear` pulse, sweeps all neurons, applying v / 2^k with correct zero/underflow/special handling, streams each decayed value out over a valid/ready handshake, and writes it back.
- Sits between the potential adder (update port) and the spike comparator (output stream).

---
 rtl/potential_decay_pkg.sv | 16 +
 rtl/fp_pow2_decay.sv | 39 +++
 rtl/potential_decay_engine.sv | 133 +++++++++++++
 tb/tb_potential_decay_engine.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/potential_decay_pkg.sv
// Shared constants for the potential decay engine: IEEE-754 single field layout,
// sweep FSM state encodings and the flushed-magnitude value.
package potential_decay_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SWEEP = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    // Magnitude (exponent + mantissa) of a signed zero.
    localparam logic [EXP_W+MAN_W-1:0] FLUSH_ZERO = '0;

endpackage

// File: rtl/fp_pow2_decay.sv
// Combinational divide of an IEEE-754 single by 2^shift via exponent subtraction,
// flushing underflow to signed zero and passing Inf/NaN through untouched.
module fp_pow2_decay
    import potential_decay_pkg::*;
#(
    parameter int SHIFT_W = 3
) (
    input  logic [31:0]        potential,
    input  logic [SHIFT_W-1:0] shift,
    output logic [31:0]        decayed,
    output logic               flushed
);

    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [EXP_W-1:0] k_ext;
    logic [MAN_W-1:0] mantissa;

    assign sign     = potential[31];
    assign exponent = potential[MAN_W +: EXP_W];
    assign mantissa = potential[MAN_W-1:0];
    assign k_ext    = EXP_W'(shift);

    always_comb begin
        decayed = potential;
        flushed = 1'b0;
        if (exponent == EXP_SPECIAL) begin
            decayed = potential;
        end else if (exponent == '0) begin
            decayed = {sign, FLUSH_ZERO};
        end else if (exponent <= k_ext) begin
            decayed = {sign, FLUSH_ZERO};
            flushed = 1'b1;
        end else begin
            decayed = {sign, exponent - k_ext, mantissa};
        end
    end

endmodule

// File: rtl/potential_decay_engine.sv
// Sweeping membrane-potential decay engine: per-timestep v / 2^k over all neurons,
// streamed out with valid/ready and written back. Optional POTENTIAL_DECAY_STATS_EN.
module potential_decay_engine
    import potential_decay_pkg::*;
#(
    parameter int NEURONS = 16,
    parameter int ADDR_W  = 4,
    parameter int SHIFT_W = 3
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               init_valid,
    input  logic [ADDR_W-1:0]  init_address,
    input  logic [31:0]        init_potential,
    input  logic [SHIFT_W-1:0] init_shift,
    input  logic               update_valid,
    input  logic [ADDR_W-1:0]  update_address,
    input  logic [31:0]        update_potential,
    output logic               wr_ready,
    input  logic               clear,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_address,
    output logic [31:0]        out_potential,
`ifdef POTENTIAL_DECAY_STATS_EN
    output logic               sweep_done,
    output logic [ADDR_W:0]    flush_count
`else
    output logic               sweep_done
`endif
);

    logic [1:0]         state;
    logic [ADDR_W-1:0]  index;
    logic [31:0]        pot_mem   [NEURONS];
    logic [SHIFT_W-1:0] shift_mem [NEURONS];
    logic [31:0]        decayed;
    logic               flushed;
    logic               handshake;
    logic               last;

    assign handshake = (state == HOLD) && out_ready;
    assign last      = (index == ADDR_W'(NEURONS - 1));
    assign busy      = (state != IDLE);
    assign wr_ready  = (state == IDLE);

    fp_pow2_decay #(
        .SHIFT_W (SHIFT_W)
    ) u_decay (
        .potential (pot_mem[index]),
        .shift     (shift_mem[index]),
        .decayed   (decayed),
        .flushed   (flushed)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            index         <= '0;
            out_valid     <= 1'b0;
            out_address   <= '0;
            out_potential <= '0;
            sweep_done    <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= SWEEP;
                        index <= '0;
                    end
                end
                SWEEP: begin
                    out_potential <= decayed;
                    out_address   <= index;
                    out_valid     <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last) begin
                            sweep_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            index <= index + 1'b1;
                            state <= SWEEP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Init outranks update on the same entry; write-back only happens while busy.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NEURONS; i++) begin
                pot_mem[i]   <= '0;
                shift_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NEURONS; i++) begin
                if (wr_ready && init_valid && init_address == ADDR_W'(i)) begin
                    pot_mem[i]   <= init_potential;
                    shift_mem[i] <= init_shift;
                end else if (wr_ready && update_valid && update_address == ADDR_W'(i)) begin
                    pot_mem[i] <= update_potential;
                end else if (handshake && index == ADDR_W'(i)) begin
                    pot_mem[i] <= out_potential;
                end
            end
        end
    end

`ifdef POTENTIAL_DECAY_STATS_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            flush_count <= '0;
        end else if (state == IDLE && clear) begin
            flush_count <= '0;
        end else if (state == SWEEP && flushed) begin
            flush_count <= flush_count + 1'b1;
        end
    end
`else
    logic unused_flushed;
    assign unused_flushed = flushed;
`endif

endmodule

// File: tb/tb_potential_decay_engine.sv
// Scoreboard bench for potential_decay_engine: a reference model predicts each sweep's
// output stream, a monitor pops and compares on every handshake.
module tb_potential_decay_engine;

    localparam int NEURONS = 16;
    localparam int ADDR_W  = 4;
    localparam int SHIFT_W = 3;

    logic               CLK = 1'b0;
    logic               RESET_N = 1'b0;
    logic               init_valid, update_valid, clear, out_ready;
    logic [ADDR_W-1:0]  init_address, update_address;
    logic [31:0]        init_potential, update_potential;
    logic [SHIFT_W-1:0] init_shift;
    logic               wr_ready, busy, out_valid, sweep_done;
    logic [ADDR_W-1:0]  out_address;
    logic [31:0]        out_potential;
`ifdef POTENTIAL_DECAY_STATS_EN
    logic [ADDR_W:0]    flush_count;
`endif

    potential_decay_engine #(
        .NEURONS (NEURONS),
        .ADDR_W  (ADDR_W),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .init_valid       (init_valid),
        .init_address     (init_address),
        .init_potential   (init_potential),
        .init_shift       (init_shift),
        .update_valid     (update_valid),
        .update_address   (update_address),
        .update_potential (update_potential),
        .wr_ready         (wr_ready),
        .clear            (clear),
        .busy             (busy),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_address      (out_address),
        .out_potential    (out_potential),
`ifdef POTENTIAL_DECAY_STATS_EN
        .sweep_done       (sweep_done),
        .flush_count      (flush_count)
`else
        .sweep_done       (sweep_done)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       pot;
    } exp_t;

    int          compared = 0;
    int          mismatched = 0;
    exp_t        exp_q[$];
    logic [31:0] model_pot [NEURONS];
    int          model_shift [NEURONS];
    int          exp_flush = 0;
    int          done_count = 0;
    int          bp_mode = 0;
    bit          stall_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: value / 2^k on a float is an exponent decrement; below the
    // smallest normal it becomes a signed zero, Inf/NaN and zero stay put.
    function automatic logic [31:0] ref_decay(input logic [31:0] v, input int k);
        int e;
        int ne;
        e  = int'(v[30:23]);
        ne = e - k;
        if (e == 255) return v;
        if (e == 0 || ne <= 0) return {v[31], 31'd0};
        return {v[31], ne[7:0], v[22:0]};
    endfunction

    function automatic bit ref_flushed(input logic [31:0] v, input int k);
        int e;
        e = int'(v[30:23]);
        return (e != 0) && (e != 255) && (e <= k);
    endfunction

    function automatic logic [31:0] rand_pot();
        logic        s;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return {s, 8'hFF, m};
            2: return {s, 8'($urandom_range(1, 7)), m};
            3: return $urandom;
            default: return {s, 8'($urandom_range(100, 150)), m};
        endcase
    endfunction

    task automatic push_sweep();
        logic [31:0] v;
        logic [31:0] d;
        exp_t        e;
        exp_flush = 0;
        for (int i = 0; i < NEURONS; i++) begin
            v = model_pot[i];
            d = ref_decay(v, model_shift[i]);
            if (ref_flushed(v, model_shift[i])) exp_flush++;
            e.addr = ADDR_W'(i);
            e.pot  = d;
            exp_q.push_back(e);
            model_pot[i] = d;
        end
    endtask

    // Called at posedge+1 while idle; holds the requests for exactly one cycle.
    task automatic drive_write(input bit iv, input int ia, input logic [31:0] ip, input int is,
                               input bit uv, input int ua, input logic [31:0] up, input bit clr);
        check("wr_ready_idle", wr_ready, 1);
        init_valid       = iv;
        init_address     = ADDR_W'(ia);
        init_potential   = ip;
        init_shift       = SHIFT_W'(is);
        update_valid     = uv;
        update_address   = ADDR_W'(ua);
        update_potential = up;
        clear            = clr;
        if (iv) begin
            model_pot[ia]   = ip;
            model_shift[ia] = is;
        end
        if (uv && !(iv && ia == ua)) model_pot[ua] = up;
        if (clr) push_sweep();
        @(posedge CLK);
        #1;
        init_valid   = 1'b0;
        update_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic wait_sweep();
        int start;
        int n;
        start = done_count;
        n = 0;
        while (done_count == start && n < 1000) begin
            @(posedge CLK);
            n++;
        end
        #1;
        if (done_count == start) begin
            compared++;
            mismatched++;
            $display("FAIL sweep_timeout: got no sweep_done, expected one within 1000 cycles");
        end
        check("queue_drained", 64'(exp_q.size()), 0);
    endtask

    task automatic do_sweep();
        drive_write(0, 0, 0, 0, 0, 0, 0, 1);
        wait_sweep();
    endtask

    // Monitor: handshake scoreboard, hold stability, sweep_done and flush count.
    bit                prev_stall = 0;
    bit                expect_done = 0;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_pot;
    exp_t              got;

    always @(negedge CLK) begin
        if (!RESET_N) begin
            prev_stall  = 0;
            expect_done = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_address", out_address, prev_addr);
                check("hold_potential", out_potential, prev_pot);
            end
            if (expect_done || sweep_done) begin
                check("sweep_done", sweep_done, expect_done);
                if (sweep_done) begin
                    done_count++;
`ifdef POTENTIAL_DECAY_STATS_EN
                    check("flush_count", flush_count, exp_flush);
`endif
                end
            end
            expect_done = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_output: got addr %0d pot %h, expected none",
                             out_address, out_potential);
                end else begin
                    got = exp_q.pop_front();
                    check("out_address", out_address, got.addr);
                    check("out_potential", out_potential, got.pot);
                end
                if (out_address == ADDR_W'(NEURONS - 1)) expect_done = 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_addr  = out_address;
            prev_pot   = out_potential;
        end
    end

    // Downstream ready: always, random, or a single 5-cycle stall on neuron 1.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (bp_mode == 1) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else if (bp_mode == 2 && !stall_done && out_valid && out_address == 1) begin
                out_ready = 1'b0;
                repeat (5) @(posedge CLK);
                #1;
                out_ready  = 1'b1;
                stall_done = 1;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        compared++;
        mismatched++;
        $display("FAIL watchdog: got no completion, expected finish before 2000000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog");
    end

    initial begin
        init_valid = 0; update_valid = 0; clear = 0;
        init_address = 0; update_address = 0;
        init_potential = 0; update_potential = 0; init_shift = 0;
        for (int i = 0; i < NEURONS; i++) begin
            model_pot[i]   = 32'h0;
            model_shift[i] = 0;
        end
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_address", out_address, 0);
        check("rst_out_potential", out_potential, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_ready", wr_ready, 1);
`ifdef POTENTIAL_DECAY_STATS_EN
        check("rst_flush_count", flush_count, 0);
`endif
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // Two initialised neurons, rest zero; also the clear-to-out_valid latency.
        drive_write(1, 0, 32'h42C80000, 1, 0, 0, 0, 0);
        drive_write(1, 1, 32'h42C80000, 3, 0, 0, 0, 0);
        drive_write(0, 0, 0, 0, 0, 0, 0, 1);
        check("lat_busy", busy, 1);
        check("lat_wr_ready", wr_ready, 0);
        check("lat_valid_early", out_valid, 0);
        @(posedge CLK);
        #1;
        check("lat_valid", out_valid, 1);
        check("lat_address", out_address, 0);
        wait_sweep();

        // Negative value, two sweeps prove write-back.
        drive_write(1, 2, 32'hC2C80000, 2, 0, 0, 0, 0);
        do_sweep();
        do_sweep();

        // Underflow flush and Inf pass-through.
        drive_write(1, 3, 32'h01800000, 3, 0, 0, 0, 0);
        drive_write(1, 4, 32'h7F800000, 7, 0, 0, 0, 0);
        do_sweep();

        // Backpressure on neuron 1.
        bp_mode = 2;
        do_sweep();
        bp_mode = 0;
        check("stall_applied", stall_done, 1);

        // clear and update while busy are ignored.
        drive_write(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) @(posedge CLK);
        #1;
        check("busy_mid", busy, 1);
        check("wr_ready_busy", wr_ready, 0);
        clear = 1; update_valid = 1; update_address = 5; update_potential = 32'h3F800000;
        @(posedge CLK);
        #1;
        clear = 0; update_valid = 0;
        wait_sweep();
        repeat (6) @(posedge CLK);
        #1;
        check("no_restart_busy", busy, 0);
        check("no_restart_valid", out_valid, 0);

        // Update in the same cycle as clear is seen by the sweep.
        drive_write(0, 0, 0, 0, 1, 0, 32'h40000000, 1);
        wait_sweep();

        // Reset mid-sweep aborts everything.
        drive_write(1, 7, 32'h42C80000, 1, 0, 0, 0, 1);
        repeat (5) @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        for (int i = 0; i < NEURONS; i++) begin
            model_pot[i]   = 32'h0;
            model_shift[i] = 0;
        end
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        do_sweep();

        // Random writes, collisions and backpressure.
        bp_mode = 1;
        repeat (20) begin
            int nw;
            nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++) begin
                int ia;
                int ua;
                ia = $urandom_range(0, NEURONS - 1);
                ua = ($urandom_range(0, 3) == 0) ? ia : $urandom_range(0, NEURONS - 1);
                drive_write($urandom_range(0, 1), ia, rand_pot(), $urandom_range(0, 7),
                            $urandom_range(0, 1), ua, rand_pot(), 0);
            end
            drive_write(0, 0, 0, 0, $urandom_range(0, 1), $urandom_range(0, NEURONS - 1),
                        rand_pot(), 1);
            wait_sweep();
        end
        bp_mode = 0;
        repeat (3) @(posedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
